// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: byte-serial configuration loader for fpga_top.
// Bytes arrive over a valid/ready handshake and are assembled LSB-first in a
// shadow register. A trailing XOR checksum byte gates an atomic one-cycle
// commit of the shadow into the active select buses. If the checksum fails,
// the image is dropped, the sticky error flag is raised, and the fabric keeps
// its previous configuration.
module fpga_cfg_loader #(
  parameter int BRB_W = 900,
  parameter int BSB_W = 1728,
  parameter int LB_W  = 80,
  parameter int IO_W  = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [BRB_W-1:0]    brbselect,
  output logic [BSB_W-1:0]    bsbselect,
  output logic [LB_W-1:0]     lbselect,
  output logic [IO_W-1:0]     leftioselect,
  output logic [IO_W-1:0]     rightioselect,
  output logic [IO_W-1:0]     topioselect,
  output logic [IO_W-1:0]     bottomioselect,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                cfg_loaded
);

  localparam int CFG_W     = BRB_W + BSB_W + LB_W + 4 * IO_W;
  localparam int NBYTES    = (CFG_W + 7) / 8;
  localparam int CNT_W     = $clog2(NBYTES);
  // Number of real config bits carried by the final payload byte; the rest is pad.
  localparam int LAST_BITS = CFG_W - 8 * (NBYTES - 1);

  // Bit offsets of each bus inside the packed config, LSB first.
  localparam int BSB_OFS   = BRB_W;
  localparam int LB_OFS    = BSB_OFS + BSB_W;
  localparam int LIO_OFS   = LB_OFS + LB_W;
  localparam int RIO_OFS   = LIO_OFS + IO_W;
  localparam int TIO_OFS   = RIO_OFS + IO_W;
  localparam int BIO_OFS   = TIO_OFS + IO_W;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        csum;
  logic [CFG_W-1:0]  shadow;
  logic [CFG_W-1:0]  active;
  logic              accept;

  assign accept = cfg_valid && cfg_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the handshake and busy outputs, which depend only on state.
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
        if (accept && (cnt == LAST_IDX)) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
        if (accept) begin
          state_nxt = (cfg_data == csum) ? COMMIT : IDLE;
        end
      end
      COMMIT: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Byte assembly, running checksum, commit of the shadow, and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      csum       <= '0;
      shadow     <= '0;
      active     <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      cfg_loaded <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            csum  <= '0;
            error <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            // Pad bits of the final byte still enter the checksum but are not stored.
            csum <= csum ^ cfg_data;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
              shadow[CFG_W-1 -: LAST_BITS] <= cfg_data[LAST_BITS-1:0];
            end else begin
              shadow[{cnt, 3'b000} +: 8] <= cfg_data;
            end
          end
        end
        CHECK: begin
          if (accept && (cfg_data != csum)) begin
            error <= 1'b1;
          end
        end
        COMMIT: begin
          active     <= shadow;
          done       <= 1'b1;
          cfg_loaded <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign brbselect      = active[0       +: BRB_W];
  assign bsbselect      = active[BSB_OFS +: BSB_W];
  assign lbselect       = active[LB_OFS  +: LB_W];
  assign leftioselect   = active[LIO_OFS +: IO_W];
  assign rightioselect  = active[RIO_OFS +: IO_W];
  assign topioselect    = active[TIO_OFS +: IO_W];
  assign bottomioselect = active[BIO_OFS +: IO_W];

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed testbench for fpga_cfg_loader: reset, good image, bad checksum,
// backpressure, reset mid-load, pad byte with an ignored mid-load start.
module tb_fpga_cfg_loader;

  localparam int BRB_W  = 900;
  localparam int BSB_W  = 1728;
  localparam int LB_W   = 80;
  localparam int IO_W   = 30;
  localparam int CFG_W  = 2828;
  localparam int NBYTES = 354;

  logic              clk;
  logic              rst;
  logic              start;
  logic [7:0]        cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [BRB_W-1:0]  brbselect;
  logic [BSB_W-1:0]  bsbselect;
  logic [LB_W-1:0]   lbselect;
  logic [IO_W-1:0]   leftioselect;
  logic [IO_W-1:0]   rightioselect;
  logic [IO_W-1:0]   topioselect;
  logic [IO_W-1:0]   bottomioselect;
  logic              busy;
  logic              done;
  logic              error;
  logic              cfg_loaded;

  fpga_cfg_loader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_data       (cfg_data),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .brbselect      (brbselect),
    .bsbselect      (bsbselect),
    .lbselect       (lbselect),
    .leftioselect   (leftioselect),
    .rightioselect  (rightioselect),
    .topioselect    (topioselect),
    .bottomioselect (bottomioselect),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .cfg_loaded     (cfg_loaded)
  );

  int total = 0;
  int bad   = 0;
  int xfers = 0;
  int done_pulses = 0;

  logic [7:0]       img [NBYTES];
  logic [CFG_W-1:0] obs;

  assign obs = {bottomioselect, topioselect, rightioselect, leftioselect,
                lbselect, bsbselect, brbselect};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count handshakes and done cycles independently of the stimulus tasks.
  always @(posedge clk) if (cfg_valid === 1'b1 && cfg_ready === 1'b1) xfers++;
  always @(negedge clk) if (done === 1'b1) done_pulses++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Expected packed config: byte k bit j -> bit 8k+j, pad beyond CFG_W dropped.
  function automatic logic [CFG_W-1:0] model();
    logic [CFG_W-1:0] m;
    m = '0;
    for (int i = 0; i < CFG_W; i++) m[i] = img[i / 8][i % 8];
    return m;
  endfunction

  function automatic int pick_idles(input int bp);
    if (bp == 0) return 0;
    return 1 + (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
  endfunction

  task automatic clear_img();
    for (int k = 0; k < NBYTES; k++) img[k] = 8'h00;
  endtask

  task automatic set_img_test2();
    clear_img();
    img[0]   = 8'h20;
    img[338] = 8'h10;
    img[349] = 8'h80;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    cfg_valid = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Present one byte after some idle cycles; returns once it will be taken at the next edge.
  task automatic send(input logic [7:0] b, input int idles);
    int t;
    for (int i = 0; i < idles; i++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_data  = 8'($urandom);
    end
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data  = b;
    t = 0;
    while (cfg_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (cfg_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout got cfg_ready=%b want 1", cfg_ready);
    end
  endtask

  // Stream the whole image and the checksum; optional start pulse before byte start_at.
  task automatic stream(input logic [7:0] chk, input int bp, input int start_at);
    for (int k = 0; k < NBYTES; k++) begin
      if (k == start_at) begin
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
      end
      send(img[k], pick_idles(bp));
    end
    send(chk, pick_idles(bp));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (obs !== '0) begin bad++; $display("FAIL reset_selects got=%0d set bits want 0", $countones(obs)); end
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want 0", cfg_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want 0", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want 0", error); end
    total++; if (cfg_loaded !== 1'b0) begin bad++; $display("FAIL reset_loaded got=%b want 0", cfg_loaded); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || cfg_ready !== 1'b0) begin bad++; $display("FAIL post_reset_idle got busy=%b ready=%b want 0 0", busy, cfg_ready); end
  endtask

  task automatic test_good_image();
    int d0;
    set_img_test2();
    d0 = done_pulses;
    start_pulse();
    stream(8'hB0, 0, -1);
    @(negedge clk);
    cfg_valid = 1'b0;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL good_done_early got=%b want 0", done); end
    total++; if (cfg_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL good_commit_state got ready=%b busy=%b want 0 1", cfg_ready, busy); end
    total++; if (obs !== '0) begin bad++; $display("FAIL good_selects_early got=%0d set bits want 0", $countones(obs)); end
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL good_done got=%b want 1", done); end
    total++; if (brbselect[5] !== 1'b1) begin bad++; $display("FAIL good_brb5 got=%b want 1", brbselect[5]); end
    total++; if (leftioselect[0] !== 1'b1) begin bad++; $display("FAIL good_left0 got=%b want 1", leftioselect[0]); end
    total++; if (bottomioselect[1] !== 1'b1) begin bad++; $display("FAIL good_bottom1 got=%b want 1", bottomioselect[1]); end
    total++; if ($countones(obs) != 3) begin bad++; $display("FAIL good_popcount got=%0d want 3", $countones(obs)); end
    total++; if (obs !== model()) begin bad++; $display("FAIL good_image got=%0d differing bits want 0", $countones(obs ^ model())); end
    total++; if (cfg_loaded !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL good_flags got loaded=%b error=%b want 1 0", cfg_loaded, error); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL good_after got done=%b busy=%b want 0 0", done, busy); end
    total++; if (done_pulses - d0 != 1) begin bad++; $display("FAIL good_done_pulses got=%0d want 1", done_pulses - d0); end
  endtask

  task automatic test_bad_checksum();
    logic [CFG_W-1:0] prev;
    int d0;
    prev = obs;
    d0   = done_pulses;
    clear_img();
    start_pulse();
    stream(8'hB1, 0, -1);
    @(negedge clk);
    cfg_valid = 1'b0;
    total++; if (error !== 1'b1) begin bad++; $display("FAIL bad_error got=%b want 1", error); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bad_busy got=%b want 0", busy); end
    repeat (3) @(negedge clk);
    total++; if (obs !== prev) begin bad++; $display("FAIL bad_selects_kept got=%0d differing bits want 0", $countones(obs ^ prev)); end
    total++; if (cfg_loaded !== 1'b1) begin bad++; $display("FAIL bad_loaded got=%b want 1", cfg_loaded); end
    total++; if (done_pulses != d0) begin bad++; $display("FAIL bad_no_done got=%0d pulses want 0", done_pulses - d0); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL bad_error_sticky got=%b want 1", error); end
  endtask

  task automatic test_backpressure();
    int x0;
    int d0;
    set_img_test2();
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data  = 8'h55;
    x0 = xfers;
    repeat (2) @(negedge clk);
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL bp_idle_ready got=%b want 0", cfg_ready); end
    total++; if (xfers != x0) begin bad++; $display("FAIL bp_idle_xfers got=%0d want 0", xfers - x0); end
    cfg_valid = 1'b0;
    x0 = xfers;
    d0 = done_pulses;
    start_pulse();
    total++; if (error !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL bp_start got error=%b busy=%b want 0 1", error, busy); end
    stream(8'hB0, 1, -1);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data  = 8'hA5;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL bp_commit_ready got=%b want 0", cfg_ready); end
    @(negedge clk);
    cfg_valid = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b want 1", done); end
    total++; if (obs !== model()) begin bad++; $display("FAIL bp_image got=%0d differing bits want 0", $countones(obs ^ model())); end
    @(negedge clk);
    total++; if (xfers - x0 != NBYTES + 1) begin bad++; $display("FAIL bp_xfers got=%0d want %0d", xfers - x0, NBYTES + 1); end
    total++; if (done_pulses - d0 != 1) begin bad++; $display("FAIL bp_done_pulses got=%0d want 1", done_pulses - d0); end
  endtask

  task automatic test_reset_mid_load();
    set_img_test2();
    start_pulse();
    for (int k = 0; k <= 100; k++) send(img[k], 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++; if (obs !== '0) begin bad++; $display("FAIL rml_selects got=%0d set bits want 0", $countones(obs)); end
    total++; if (busy !== 1'b0 || cfg_ready !== 1'b0) begin bad++; $display("FAIL rml_idle got busy=%b ready=%b want 0 0", busy, cfg_ready); end
    total++; if (cfg_loaded !== 1'b0) begin bad++; $display("FAIL rml_loaded got=%b want 0", cfg_loaded); end
    rst = 1'b0;
    @(negedge clk);
    start_pulse();
    stream(8'hB0, 0, -1);
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rml_reload_done got=%b want 1", done); end
    total++; if (obs !== model()) begin bad++; $display("FAIL rml_reload_image got=%0d differing bits want 0", $countones(obs ^ model())); end
    total++; if (cfg_loaded !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL rml_reload_flags got loaded=%b error=%b want 1 0", cfg_loaded, error); end
    @(negedge clk);
  endtask

  task automatic test_pad_ignored_start();
    clear_img();
    img[NBYTES-1] = 8'hFF;
    start_pulse();
    stream(8'hFF, 0, 50);
    @(negedge clk);
    cfg_valid = 1'b0;
    total++; if (error !== 1'b0) begin bad++; $display("FAIL pad_error got=%b want 0", error); end
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL pad_done got=%b want 1", done); end
    total++; if (bottomioselect[29:26] !== 4'hF) begin bad++; $display("FAIL pad_bottom_top got=%h want f", bottomioselect[29:26]); end
    total++; if ($countones(obs) != 4) begin bad++; $display("FAIL pad_popcount got=%0d want 4", $countones(obs)); end
    total++; if (obs !== model()) begin bad++; $display("FAIL pad_image got=%0d differing bits want 0", $countones(obs ^ model())); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL pad_after got busy=%b error=%b want 0 0", busy, error); end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    cfg_data  = 8'h00;
    cfg_valid = 1'b0;
    test_reset();
    test_good_image();
    test_bad_checksum();
    test_backpressure();
    test_reset_mid_load();
    test_pad_ignored_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
